// File: rtl/div_unit.sv
// Sequential signed divider with MIPS DIV semantics.
// Restoring algorithm on magnitudes, one quotient bit per clock.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             div_zero,
    output logic             div_ready,
    output logic             busy,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH:0]   dsr_q, dsr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH:0]   b_ext, b_mag;
    logic [WIDTH:0]   rem_sh, trial;
    logic [WIDTH-1:0] quo_nx, rem_nx;

    assign div_zero  = (divisor == '0);
    assign div_ready = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;

    // Unsigned negation of the dividend is exact, including -2^(WIDTH-1).
    always_comb begin
        a_mag  = dividend[WIDTH-1] ? -dividend : dividend;
        b_ext  = {divisor[WIDTH-1], divisor};
        b_mag  = divisor[WIDTH-1] ? -b_ext : b_ext;
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        trial  = rem_sh - dsr_q;
        quo_nx = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        rem_nx = trial[WIDTH] ? rem_sh[WIDTH-1:0]
                              : trial[WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        count_d = count_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (div_start && !div_zero) begin
                    state_d = S_CALC;
                    rem_d   = '0;
                    quo_d   = a_mag;
                    dsr_d   = b_mag;
                    count_d = '0;
                    qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    rneg_d  = dividend[WIDTH-1];
                end
            end
            S_CALC: begin
                rem_d   = rem_nx;
                quo_d   = quo_nx;
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    lo_d    = qneg_q ? -quo_nx : quo_nx;
                    hi_d    = rneg_q ? -rem_nx : rem_nx;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            count_q <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dsr_q   <= dsr_d;
            count_q <= count_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule
